// File: rtl/mem_handshake_responder.sv
// mem_handshake_responder: wait-state big-endian memory responder for the MOV/MOC handshake.
// Optional MEM_ALIGN_CHECK_EN flags misaligned halfword/word accesses instead of aligning them down.
module mem_handshake_responder #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mov,
    input  logic              rw,
    input  logic [1:0]        dl,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              moc,
    output logic              busy,
    output logic              align_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t st, nxt;
    logic [7:0]        mem [2**ADDR_W];
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] a_q, base, a0, a1, a2, a3;
    logic              rw_q, hw, wd, mis, err, acc, we, err_q;
    logic [1:0]        dl_q;
    logic [31:0]       d_q, rdata;
    assign hw  = dl_q == 2'b01;
    assign wd  = dl_q[1];
    assign mis = (hw & a_q[0]) | (wd & |a_q[1:0]);
`ifdef MEM_ALIGN_CHECK_EN
    assign err  = mis;
    assign base = a_q;
`else
    assign err  = 1'b0;
    assign base = wd ? {a_q[ADDR_W-1:2], 2'b00} : hw ? {a_q[ADDR_W-1:1], 1'b0} : a_q;
`endif
    // Byte offsets wrap naturally modulo the address width.
    assign a0    = base;
    assign a1    = base + ADDR_W'(1);
    assign a2    = base + ADDR_W'(2);
    assign a3    = base + ADDR_W'(3);
    assign acc   = st == S_WAIT && cnt == 4'd0;
    assign we    = acc && !rw_q && !err;
    assign rdata = err ? 32'd0 : wd ? {mem[a0], mem[a1], mem[a2], mem[a3]} :
                   hw ? {16'd0, mem[a0], mem[a1]} : {24'd0, mem[a0]};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= S_IDLE;
        else        st <= nxt;
    end
    always_comb begin
        nxt = st;
        nxt = (st == S_IDLE) ? (mov ? S_WAIT : S_IDLE) :
              (st == S_WAIT) ? (cnt == 4'd0 ? S_DONE : S_WAIT) :
                               (mov ? S_DONE : S_IDLE);
    end
    always_comb begin
        busy      = st != S_IDLE;
        moc       = st == S_DONE;
        align_err = err_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 4'd0;
            a_q      <= '0;
            rw_q     <= 1'b0;
            dl_q     <= 2'b00;
            d_q      <= 32'd0;
            data_out <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            if (st == S_IDLE && mov) begin
                cnt  <= 4'(WAIT_STATES);
                a_q  <= address;
                rw_q <= rw;
                dl_q <= dl;
                d_q  <= data_in;
            end else if (st == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (acc && rw_q) data_out <= rdata;
            if (acc) err_q <= err;
            else if (st == S_DONE && !mov) err_q <= 1'b0;
        end
    end
    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[a0] <= wd ? d_q[31:24] : hw ? d_q[15:8] : d_q[7:0];
            if (hw || wd) mem[a1] <= wd ? d_q[23:16] : d_q[7:0];
            if (wd) begin
                mem[a2] <= d_q[15:8];
                mem[a3] <= d_q[7:0];
            end
        end
    end
endmodule
